// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared widths, reset vector and FIFO entry type for instruction fetch
package instruction_fetch_pkg;

  localparam int WORD_W     = 16;
  localparam int ROM_AW     = 15;
  localparam int FIFO_DEPTH = 2;

  localparam logic [WORD_W-1:0] RESET_VECTOR = 16'h0000;

  // One buffered instruction: where it came from and what it is.
  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] word;
  } fetch_entry_t;

  // Fetch pointer advance; wraps naturally from 0xFFFF to 0x0000.
  function automatic logic [WORD_W-1:0] ptr_next(input logic [WORD_W-1:0] p);
    return p + WORD_W'(1);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - ROM request/response and decoder handshake bundle
interface instruction_fetch_if
  import instruction_fetch_pkg::*;
();

  logic              redirect;
  logic [WORD_W-1:0] redirect_addr;
  logic              rom_en;
  logic [ROM_AW-1:0] rom_addr;
  logic [WORD_W-1:0] rom_data;
  logic [WORD_W-1:0] instr;
  logic [WORD_W-1:0] instr_addr;
  logic              instr_valid;
  logic              instr_ready;

  // Fetch unit side.
  modport master (
    input  redirect, redirect_addr, rom_data, instr_ready,
    output rom_en, rom_addr, instr, instr_addr, instr_valid
  );

  // ROM / decoder / branch-unit side.
  modport slave (
    output redirect, redirect_addr, rom_data, instr_ready,
    input  rom_en, rom_addr, instr, instr_addr, instr_valid
  );

endinterface

// File: rtl/instruction_fetch_fetch_fifo.sv
// rtl/instruction_fetch_fetch_fifo.sv - small prefetch FIFO of {addr, word} entries with flush
module fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  output fetch_entry_t     head_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     last_q;
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W-1:0] wr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;
  logic             full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid_o = (count_q != '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i & valid_o;
  assign count_o = count_q;

  // When empty, keep showing the last consumed entry so the head does not
  // jump to stale storage.
  assign head_o = valid_o ? mem_q[rd_q] : last_q;

  // Storage, pointers and occupancy; flush empties but still honours a pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      last_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_pop) begin
        last_q <= mem_q[rd_q];
      end
      if (flush_i) begin
        rd_q    <= '0;
        wr_q    <= '0;
        count_q <= '0;
      end else begin
        if (push_i) begin
          mem_q[wr_q] <= push_data_i;
          wr_q        <= ptr_inc(wr_q);
        end
        if (do_pop) begin
          rd_q <= ptr_inc(rd_q);
        end
        count_q <= count_q + CNT_W'(push_i) - CNT_W'(do_pop);
      end
    end
  end

  // Issue throttling upstream guarantees a push never lands on a full FIFO.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && full && !do_pop && !flush_i));

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch pointer, ROM request issue, redirect handling and prefetch buffer
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int DATA_W = instruction_fetch_pkg::WORD_W,
  parameter int ROM_AW = instruction_fetch_pkg::ROM_AW,
  parameter int DEPTH  = instruction_fetch_pkg::FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  logic [DATA_W-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [DATA_W-1:0] tag_q, tag_d;
  logic              inflight_q, inflight_d;

  fetch_entry_t      head;
  fetch_entry_t      push_data;
  logic              fifo_valid;
  logic [CNT_W-1:0]  fifo_count;
  logic              pop;
  logic              push;
  logic              issue;
  logic [SUM_W-1:0]  demand;
  logic [SUM_W-1:0]  limit;

  // Decoder-facing outputs are forced quiet while reset is held.
  assign bus.instr_valid = fifo_valid & ~reset;
  assign bus.instr       = reset ? '0 : head.word;
  assign bus.instr_addr  = reset ? '0 : head.addr;
  assign pop             = bus.instr_valid & bus.instr_ready;

  // Buffered plus in-flight words may not exceed DEPTH after this cycle's pop;
  // pop is added to the limit rather than subtracted from demand to avoid underflow.
  assign demand = SUM_W'(fifo_count) + SUM_W'(inflight_q);
  assign limit  = SUM_W'(DEPTH) + SUM_W'(pop);
  assign issue  = ~reset & ~bus.redirect & (demand < limit);

  assign bus.rom_en   = issue;
  assign bus.rom_addr = fetch_ptr_q[ROM_AW-1:0];

  // A response arriving during a redirect belongs to the abandoned path.
  assign push      = inflight_q & ~bus.redirect;
  assign push_data = '{addr: tag_q, word: bus.rom_data};

  // Next fetch pointer, in-flight flag and tag; redirect wins over issue.
  always_comb begin
    fetch_ptr_d = fetch_ptr_q;
    tag_d       = tag_q;
    inflight_d  = inflight_q;
    if (bus.redirect) begin
      fetch_ptr_d = bus.redirect_addr;
      inflight_d  = 1'b0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        fetch_ptr_d = ptr_next(fetch_ptr_q);
        tag_d       = fetch_ptr_q;
      end
    end
  end

  // Fetch-side state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_ptr_q <= RESET_VECTOR;
      tag_q       <= '0;
      inflight_q  <= 1'b0;
    end else begin
      fetch_ptr_q <= fetch_ptr_d;
      tag_q       <= tag_d;
      inflight_q  <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .flush_i     (bus.redirect),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .valid_o     (fifo_valid),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed vector bench for instruction_fetch
module tb_instruction_fetch;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  instruction_fetch_if bus ();

  instruction_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    return {1'b0, a[14:0]} ^ 16'hA5A5;
  endfunction

  // Registered ROM: word valid exactly one cycle after the request.
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= rom_word({1'b0, bus.rom_addr});
  end

  typedef struct {
    string       name;
    logic        rst;
    logic        redir;
    logic [15:0] raddr;
    logic        rdy;
    logic        en;
    logic [14:0] ra;
    logic        v;
    logic [15:0] ia;
    logic        zero;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic rst, input logic redir,
                              input logic [15:0] raddr, input logic rdy, input logic en,
                              input logic [14:0] ra, input logic v, input logic [15:0] ia,
                              input logic zero);
    vec_t t;
    t.name = name; t.rst = rst; t.redir = redir; t.raddr = raddr; t.rdy = rdy;
    t.en = en; t.ra = ra; t.v = v; t.ia = ia; t.zero = zero;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called just after a falling edge: drive, settle, compare, then cross the rising edge.
  task automatic run(input vec_t t);
    reset             = t.rst;
    bus.redirect      = t.redir;
    bus.redirect_addr = t.raddr;
    bus.instr_ready   = t.rdy;
    #1;
    chk({t.name, ".rom_en"}, {31'd0, bus.rom_en}, {31'd0, t.en});
    if (t.en) chk({t.name, ".rom_addr"}, {17'd0, bus.rom_addr}, {17'd0, t.ra});
    chk({t.name, ".instr_valid"}, {31'd0, bus.instr_valid}, {31'd0, t.v});
    if (t.v) begin
      chk({t.name, ".instr_addr"}, {16'd0, bus.instr_addr}, {16'd0, t.ia});
      chk({t.name, ".instr"}, {16'd0, bus.instr}, {16'd0, rom_word(t.ia)});
    end
    if (t.zero) begin
      chk({t.name, ".instr_zero"}, {16'd0, bus.instr}, 32'd0);
      chk({t.name, ".instr_addr_zero"}, {16'd0, bus.instr_addr}, 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc(input string name, input logic redir, input logic [15:0] raddr,
                     input logic en, input logic [14:0] ra, input logic v, input logic [15:0] ia);
    vec_t t;
    t.name = name; t.rst = 1'b0; t.redir = redir; t.raddr = raddr; t.rdy = 1'b1;
    t.en = en; t.ra = ra; t.v = v; t.ia = ia; t.zero = 1'b0;
    run(t);
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    reset             = 1'b1;
    bus.redirect      = 1'b0;
    bus.redirect_addr = '0;
    bus.instr_ready   = 1'b0;
    bus.rom_data      = '0;

    // name          rst redir raddr   rdy en ra       v  ia       zero
    add("reset0",     1, 0, 16'h0000, 0, 0, 15'h0000, 0, 16'h0000, 1);
    add("reset1",     1, 0, 16'h0000, 0, 0, 15'h0000, 0, 16'h0000, 1);
    // decoder stalled from the start: two requests, then hold the head
    add("stall_c0",   0, 0, 16'h0000, 0, 1, 15'h0000, 0, 16'h0000, 1);
    add("stall_c1",   0, 0, 16'h0000, 0, 1, 15'h0001, 0, 16'h0000, 0);
    add("stall_c2",   0, 0, 16'h0000, 0, 0, 15'h0000, 1, 16'h0000, 0);
    add("stall_c3",   0, 0, 16'h0000, 0, 0, 15'h0000, 1, 16'h0000, 0);
    add("stall_c4",   0, 0, 16'h0000, 0, 0, 15'h0000, 1, 16'h0000, 0);
    add("release_c5", 0, 0, 16'h0000, 1, 1, 15'h0002, 1, 16'h0000, 0);
    add("release_c6", 0, 0, 16'h0000, 1, 1, 15'h0003, 1, 16'h0001, 0);
    add("release_c7", 0, 0, 16'h0000, 1, 1, 15'h0004, 1, 16'h0002, 0);
    add("release_c8", 0, 0, 16'h0000, 1, 1, 15'h0005, 1, 16'h0003, 0);
    // one-cycle reset mid-stream, then stream from address 0
    add("midreset",   1, 0, 16'h0000, 1, 0, 15'h0000, 0, 16'h0000, 1);
    add("stream_c0",  0, 0, 16'h0000, 1, 1, 15'h0000, 0, 16'h0000, 1);
    add("stream_c1",  0, 0, 16'h0000, 1, 1, 15'h0001, 0, 16'h0000, 0);
    add("stream_c2",  0, 0, 16'h0000, 1, 1, 15'h0002, 1, 16'h0000, 0);
    add("stream_c3",  0, 0, 16'h0000, 1, 1, 15'h0003, 1, 16'h0001, 0);
    add("stream_c4",  0, 0, 16'h0000, 1, 1, 15'h0004, 1, 16'h0002, 0);
    add("stream_c5",  0, 0, 16'h0000, 1, 1, 15'h0005, 1, 16'h0003, 0);
    add("stream_c6",  0, 0, 16'h0000, 1, 1, 15'h0006, 1, 16'h0004, 0);

    @(negedge clk);
    foreach (vecs[i]) run(vecs[i]);

    // redirect to 0x0100 with head 5 valid and 6 in flight; 6 and 7 must never appear
    cyc("redir100_r0", 1, 16'h0100, 0, 15'h0000, 1, 16'h0005);
    cyc("redir100_r1", 0, 16'h0000, 1, 15'h0100, 0, 16'h0000);
    cyc("redir100_r2", 0, 16'h0000, 1, 15'h0101, 0, 16'h0000);
    cyc("redir100_r3", 0, 16'h0000, 1, 15'h0102, 1, 16'h0100);
    cyc("redir100_r4", 0, 16'h0000, 1, 15'h0103, 1, 16'h0101);

    // redirect to the top of the address space, pointer wraps to zero
    cyc("redirFFFF_r0", 1, 16'hFFFF, 0, 15'h0000, 1, 16'h0102);
    cyc("redirFFFF_r1", 0, 16'h0000, 1, 15'h7FFF, 0, 16'h0000);
    cyc("redirFFFF_r2", 0, 16'h0000, 1, 15'h0000, 0, 16'h0000);
    cyc("redirFFFF_r3", 0, 16'h0000, 1, 15'h0001, 1, 16'hFFFF);
    cyc("redirFFFF_r4", 0, 16'h0000, 1, 15'h0002, 1, 16'h0000);
    cyc("redirFFFF_r5", 0, 16'h0000, 1, 15'h0003, 1, 16'h0001);

    // back-to-back redirects: 0x10 is abandoned, 0x20 wins
    cyc("b2b_r0", 1, 16'h0010, 0, 15'h0000, 1, 16'h0002);
    cyc("b2b_r1", 1, 16'h0020, 0, 15'h0000, 0, 16'h0000);
    cyc("b2b_r2", 0, 16'h0000, 1, 15'h0020, 0, 16'h0000);
    cyc("b2b_r3", 0, 16'h0000, 1, 15'h0021, 0, 16'h0000);
    cyc("b2b_r4", 0, 16'h0000, 1, 15'h0022, 1, 16'h0020);
    cyc("b2b_r5", 0, 16'h0000, 1, 15'h0023, 1, 16'h0021);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
